// File: rtl/string_receiver_if.sv
`timescale 1ns / 1ps
// string_receiver_if: single-wire LED stream input and decoded pixel/frame outputs
//   sdi          serial line from the LED string DOUT (async to clk)
//   pixel_data   last decoded 24-bit pixel, first-received bit in [23]
//   pixel_valid  one-cycle pulse, pixel_data valid
//   frame_end    one-cycle pulse when a reset (blank) low is detected
//   frame_pixels pixel count of the frame just ended
//   err_glitch   one-cycle pulse on a too-short high pulse
//   err_partial  one-cycle pulse with frame_end when bits were pending
// master drives sdi and observes results; slave is the receiver.
interface string_receiver_if;
    logic        sdi;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_end;
    logic [15:0] frame_pixels;
    logic        err_glitch;
    logic        err_partial;
    modport master (
        output sdi,
        input  pixel_data, pixel_valid, frame_end, frame_pixels, err_glitch, err_partial
    );
    modport slave (
        input  sdi,
        output pixel_data, pixel_valid, frame_end, frame_pixels, err_glitch, err_partial
    );
endinterface

// File: rtl/string_receiver.sv
`timescale 1ns / 1ps
// string_receiver: decodes a WS2812B-style single-wire stream into 24-bit pixels
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  string_receiver_if.slave: sdi in; pixel_data, pixel_valid, frame_end,
//        frame_pixels, err_glitch, err_partial out
// High-pulse widths classify bits; a long low marks the frame boundary. After
// reset nothing is decoded until one full reset-length low has been seen.
module string_receiver #(
    parameter int CLK_PERIOD_NS = 100,
    parameter int MIN_HIGH_NS   = 150,
    parameter int THRESH_NS     = 600,
    parameter int MAX_HIGH_NS   = 2000,
    parameter int RESET_NS      = 40000
) (
    input  logic             clk,
    input  logic             rst,
    string_receiver_if.slave bus
);
    localparam logic [15:0] MIN_C    = 16'((MIN_HIGH_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS);
    localparam logic [15:0] THRESH_C = 16'((THRESH_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS);
    localparam logic [15:0] MAX_C    = 16'((MAX_HIGH_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS);
    localparam logic [15:0] RESET_C  = 16'((RESET_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS);
    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;
    state_t      state;
    logic        s1, sdi_s, sdi_q;
    logic        chg, rise, fall, reset_hit;
    logic [15:0] width, pix_cnt, frame_pixels;
    logic [4:0]  bit_cnt;
    logic [23:0] shreg, pixel_data, next_pix;
    logic        pixel_valid, frame_end, err_glitch, err_partial;
    assign chg  = sdi_s ^ sdi_q;
    assign rise = chg & sdi_s;
    assign fall = chg & ~sdi_s;
    // width holds the cycles already spent at this level, so the low has lasted
    // RESET_C cycles in the cycle where width is one short of it
    assign reset_hit = ~sdi_s & ~chg & (width == RESET_C - 16'd1);
    // on a falling edge width is the full high-pulse length
    assign next_pix  = {shreg[22:0], width >= THRESH_C};
    assign bus.pixel_data   = pixel_data;
    assign bus.pixel_valid  = pixel_valid;
    assign bus.frame_end    = frame_end;
    assign bus.frame_pixels = frame_pixels;
    assign bus.err_glitch   = err_glitch;
    assign bus.err_partial  = err_partial;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            s1           <= 1'b0;
            sdi_s        <= 1'b0;
            sdi_q        <= 1'b0;
            width        <= '0;
            pix_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            pixel_data   <= '0;
            frame_pixels <= '0;
            pixel_valid  <= 1'b0;
            frame_end    <= 1'b0;
            err_glitch   <= 1'b0;
            err_partial  <= 1'b0;
        end else begin
            s1          <= bus.sdi;
            sdi_s       <= s1;
            sdi_q       <= sdi_s;
            width       <= chg ? 16'd1 : (width == 16'hFFFF ? width : width + 16'd1);
            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
            err_glitch  <= 1'b0;
            err_partial <= 1'b0;
            case (state)
                SYNC: if (reset_hit) state <= LOW;
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (reset_hit) begin
                        frame_end    <= 1'b1;
                        err_partial  <= bit_cnt != 5'd0;
                        frame_pixels <= pix_cnt;
                        pix_cnt      <= '0;
                        bit_cnt      <= '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        if (width < MIN_C) begin
                            err_glitch <= 1'b1;
                        end else if (width <= MAX_C) begin
                            shreg <= next_pix;
                            if (bit_cnt == 5'd23) begin
                                pixel_data  <= next_pix;
                                pixel_valid <= 1'b1;
                                bit_cnt     <= '0;
                                pix_cnt     <= pix_cnt == 16'hFFFF ? pix_cnt : pix_cnt + 16'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_string_receiver.sv
`timescale 1ns / 1ps
// tb_string_receiver: directed stimulus for string_receiver at 10 MHz with a
// run-length behavioural model compared against every output each cycle, plus
// literal expectations for the headline scenarios.
module tb_string_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;
    string_receiver_if bus ();
    string_receiver dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int n_pass = 0, n_total = 0, cyc = 0;
    int n_pv = 0, n_fe = 0, n_eg = 0, n_ep = 0, pv_cyc = 0, fe_cyc = 0, t_fall = 0;
    // model state: synchronizer image, current level run, decoder progress
    logic        m1, m2, x, lvl, synced;
    int          run, nb, npix;
    logic [23:0] acc;
    logic        e_pv, e_fe, e_eg, e_ep;
    logic [23:0] e_pd;
    logic [15:0] e_fp;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // Model: the line is seen two clocks late; a high run of length L ending
    // classifies as glitch (<2), bit 0 (<6), bit 1 (<=20) or idle (>20); a low
    // run reaching 400 ends a frame (or first establishes sync).
    initial forever begin
        @(posedge clk);
        cyc++;
        e_pv = 0; e_fe = 0; e_eg = 0; e_ep = 0;
        if (rst) begin
            m1 = 0; m2 = 0; lvl = 0; run = 0; synced = 0; nb = 0; npix = 0;
            acc = 0; e_pd = 0; e_fp = 0;
        end else begin
            x = m2;
            if (x != lvl) begin
                if (!x && synced) begin
                    if (run < 2) e_eg = 1;
                    else if (run <= 20) begin
                        if (run >= 6) acc = acc | (24'd1 << (23 - nb));
                        nb++;
                        if (nb == 24) begin
                            e_pv = 1; e_pd = acc; acc = 0; nb = 0;
                            if (npix < 65535) npix++;
                        end
                    end
                end
                run = 1;
            end else if (run < 65535) run++;
            lvl = x;
            if (!x && run == 400) begin
                if (synced) begin
                    e_fe = 1; e_fp = 16'(npix); e_ep = nb != 0;
                    npix = 0; nb = 0; acc = 0;
                end
                synced = 1;
            end
            m2 = m1; m1 = bus.sdi;
        end
    end
    initial forever begin
        @(negedge clk);
        check("outputs",
              {bus.pixel_valid, bus.pixel_data, bus.frame_end, bus.frame_pixels, bus.err_glitch, bus.err_partial},
              {e_pv, e_pd, e_fe, e_fp, e_eg, e_ep});
        if (bus.pixel_valid) begin n_pv++; pv_cyc = cyc; end
        if (bus.frame_end) begin n_fe++; fe_cyc = cyc; end
        if (bus.err_glitch) n_eg++;
        if (bus.err_partial) n_ep++;
    end
    task automatic hold(input logic v, input int n);
        bus.sdi = v;
        repeat (n) @(negedge clk);
    endtask
    // T1H 800 / T1L 450 -> 8/5 clocks; T0H 400 / T0L 850 -> 4/9 clocks
    task automatic send_bit(input logic b);
        hold(1'b1, b ? 8 : 4);
        t_fall = cyc;
        hold(1'b0, b ? 5 : 9);
    endtask
    task automatic send_pixel(input logic [23:0] px);
        for (int i = 23; i >= 0; i--) send_bit(px[i]);
    endtask
    int b_pv, b_fe, b_eg, b_ep;
    task automatic mark();
        b_pv = n_pv; b_fe = n_fe; b_eg = n_eg; b_ep = n_ep;
    endtask
    initial begin
        logic [23:0] px;
        bus.sdi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {bus.pixel_valid, bus.pixel_data, bus.frame_end, bus.frame_pixels,
              bus.err_glitch, bus.err_partial}, 0);
        // 1: sync low, then one pixel
        hold(1'b0, 450);
        mark();
        send_pixel(24'hA5C3F0);
        hold(1'b0, 10);
        check("t1_pv_count", n_pv - b_pv, 1);
        check("t1_pixel", bus.pixel_data, 24'hA5C3F0);
        check("t1_latency", pv_cyc - t_fall, 3);
        // 2: no sync after reset -> bits ignored; first long low only syncs
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mark();
        send_pixel(24'h5A5A5A);
        hold(1'b0, 500);
        check("t2_pv_count", n_pv - b_pv, 0);
        check("t2_fe_count", n_fe - b_fe, 0);
        // 3: three pixels then reset low; 400 low clocks plus 2 sync clocks
        mark();
        send_pixel(24'h000000);
        send_pixel(24'hFFFFFF);
        send_pixel(24'h123456);
        hold(1'b0, 500);
        check("t3_pv_count", n_pv - b_pv, 3);
        check("t3_last_pixel", bus.pixel_data, 24'h123456);
        check("t3_fe_count", n_fe - b_fe, 1);
        check("t3_frame_pixels", bus.frame_pixels, 3);
        check("t3_partial", n_ep - b_ep, 0);
        check("t3_fe_latency", fe_cyc - t_fall, 402);
        // 4: glitch in the middle of a pixel
        mark();
        px = 24'hABCDEF;
        for (int i = 23; i >= 12; i--) send_bit(px[i]);
        hold(1'b1, 1);
        hold(1'b0, 5);
        for (int i = 11; i >= 0; i--) send_bit(px[i]);
        hold(1'b0, 10);
        check("t4_glitch_count", n_eg - b_eg, 1);
        check("t4_pv_count", n_pv - b_pv, 1);
        check("t4_pixel", bus.pixel_data, 24'hABCDEF);
        hold(1'b0, 500);
        check("t4_frame_pixels", bus.frame_pixels, 1);
        // 5: partial pixel at frame end
        mark();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        hold(1'b0, 500);
        check("t5_fe_count", n_fe - b_fe, 1);
        check("t5_partial", n_ep - b_ep, 1);
        check("t5_pv_count", n_pv - b_pv, 0);
        check("t5_frame_pixels", bus.frame_pixels, 0);
        // 6: idle-high after a pixel is not a bit
        mark();
        send_pixel(24'h0F0F0F);
        hold(1'b1, 50);
        hold(1'b0, 500);
        check("t6_pv_count", n_pv - b_pv, 1);
        check("t6_pixel", bus.pixel_data, 24'h0F0F0F);
        check("t6_fe_count", n_fe - b_fe, 1);
        check("t6_errors", (n_eg - b_eg) + (n_ep - b_ep), 0);
        check("t6_frame_pixels", bus.frame_pixels, 1);
        // reset mid-pixel, then resync required
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_pixel", bus.pixel_data, 0);
        check("t6_rst_frame_pixels", bus.frame_pixels, 0);
        check("t6_rst_pulses", {bus.pixel_valid, bus.frame_end, bus.err_glitch, bus.err_partial}, 0);
        rst = 1'b0;
        mark();
        send_pixel(24'h3C3C3C);
        hold(1'b0, 10);
        check("t6_unsynced_pv", n_pv - b_pv, 0);
        hold(1'b0, 500);
        check("t6_resync_fe", n_fe - b_fe, 0);
        send_pixel(24'hC33C96);
        hold(1'b0, 10);
        check("t6_resync_pv", n_pv - b_pv, 1);
        check("t6_resync_pixel", bus.pixel_data, 24'hC33C96);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
